video_scanout: RTL

VIDEO_SCANOUT -- requirements
Module: video_scanout

---
 rtl/video_pkg.sv | 37 +++
 rtl/video_scanout_if.sv | 23 ++
 rtl/video_timing.sv | 61 ++++++
 rtl/video_scanout.sv | 88 ++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared timing constants for the 640x480@60 scanout path.
// All counter-facing constants are 10 bits wide so comparisons stay width-matched.
package video_pkg;

    localparam logic [9:0] H_VISIBLE     = 10'd640;
    localparam logic [9:0] H_FRONT_PORCH = 10'd16;
    localparam logic [9:0] H_SYNC        = 10'd96;
    localparam logic [9:0] H_BACK_PORCH  = 10'd48;
    localparam logic [9:0] H_TOTAL       = H_VISIBLE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam logic [9:0] H_SYNC_START  = H_VISIBLE + H_FRONT_PORCH;
    localparam logic [9:0] H_SYNC_END    = H_SYNC_START + H_SYNC - 10'd1;
    localparam logic [9:0] H_LAST        = H_TOTAL - 10'd1;

    localparam logic [9:0] V_VISIBLE     = 10'd480;
    localparam logic [9:0] V_FRONT_PORCH = 10'd10;
    localparam logic [9:0] V_SYNC        = 10'd2;
    localparam logic [9:0] V_BACK_PORCH  = 10'd33;
    localparam logic [9:0] V_TOTAL       = V_VISIBLE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam logic [9:0] V_SYNC_START  = V_VISIBLE + V_FRONT_PORCH;
    localparam logic [9:0] V_SYNC_END    = V_SYNC_START + V_SYNC - 10'd1;
    localparam logic [9:0] V_LAST        = V_TOTAL - 10'd1;

    localparam logic [9:0] VBLANK_START_LINE    = 10'd480;
    localparam logic [9:0] VBLANK_END_SOON_LINE = 10'd521;
    localparam logic [9:0] SWAP_FIRST_LINE      = 10'd522;
    localparam logic [9:0] SWAP_LAST_LINE       = 10'd477;

    localparam int PIPE_LAT = 4;

    // The PPU renders one 320-pixel row per two display lines, plus two
    // priming swaps during vertical blank ahead of the first visible row.
    function automatic logic is_swap_line(input logic [9:0] line);
        return (line == SWAP_FIRST_LINE) || (line == V_LAST) ||
               (line[0] && (line <= SWAP_LAST_LINE));
    endfunction

endpackage

// File: rtl/video_scanout_if.sv
// Row-RAM and palette-RAM read ports between the scanout engine and the PPU memories.
interface video_scanout_if;

    logic [8:0]  rowram_rdaddr;
    logic [9:0]  rowram_rddata;
    logic [8:0]  palram_rdaddr;
    logic [63:0] palram_rddata;

    modport master (
        output rowram_rdaddr,
        output palram_rdaddr,
        input  rowram_rddata,
        input  palram_rddata
    );

    modport slave (
        input  rowram_rdaddr,
        input  palram_rdaddr,
        output rowram_rddata,
        output palram_rddata
    );

endinterface

// File: rtl/video_timing.sv
// Free-running raster counters with visible/sync decode and registered PPU strobes.
module video_timing
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [8:0] pix_col,
    output logic       visible,
    output logic       hsync_act,
    output logic       vsync_act,
    output logic       vblank_start,
    output logic       vblank_end_soon,
    output logic       rowram_swap
);

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       vblank_start_q, vblank_start_d;
    logic       vblank_end_soon_q, vblank_end_soon_d;
    logic       rowram_swap_q, rowram_swap_d;

    always_comb begin
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
        end

        vblank_start_d    = (hcount_q == '0) && (vcount_q == VBLANK_START_LINE);
        vblank_end_soon_d = (hcount_q == '0) && (vcount_q == VBLANK_END_SOON_LINE);
        rowram_swap_d     = (hcount_q == H_LAST) && is_swap_line(vcount_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q          <= '0;
            vcount_q          <= '0;
            vblank_start_q    <= 1'b0;
            vblank_end_soon_q <= 1'b0;
            rowram_swap_q     <= 1'b0;
        end else begin
            hcount_q          <= hcount_d;
            vcount_q          <= vcount_d;
            vblank_start_q    <= vblank_start_d;
            vblank_end_soon_q <= vblank_end_soon_d;
            rowram_swap_q     <= rowram_swap_d;
        end
    end

    // Each PPU column covers two display columns.
    assign pix_col   = hcount_q[9:1];
    assign visible   = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);
    assign hsync_act = (hcount_q >= H_SYNC_START) && (hcount_q <= H_SYNC_END);
    assign vsync_act = (vcount_q >= V_SYNC_START) && (vcount_q <= V_SYNC_END);

    assign vblank_start    = vblank_start_q;
    assign vblank_end_soon = vblank_end_soon_q;
    assign rowram_swap     = rowram_swap_q;

endmodule

// File: rtl/video_scanout.sv
// Scanout top: row-RAM -> palette fetch pipeline with DE/sync delayed to stay aligned
// with the pixel data, PIPE_LAT clocks behind the raster counters.
module video_scanout
    import video_pkg::*;
#(
    parameter logic HSYNC_ACTIVE = 1'b0,
    parameter logic VSYNC_ACTIVE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    video_scanout_if.master        mem,
    output logic                   rowram_swap,
    output logic                   vblank_start,
    output logic                   vblank_end_soon,
    output logic [23:0]            vid_rgb,
    output logic                   vid_de,
    output logic                   vid_hsync,
    output logic                   vid_vsync
);

    logic [8:0] pix_col;
    logic       visible;
    logic       hsync_act;
    logic       vsync_act;

    video_timing u_timing (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_col         (pix_col),
        .visible         (visible),
        .hsync_act       (hsync_act),
        .vsync_act       (vsync_act),
        .vblank_start    (vblank_start),
        .vblank_end_soon (vblank_end_soon),
        .rowram_swap     (rowram_swap)
    );

    logic [8:0]          rowram_rdaddr_q, rowram_rdaddr_d;
    logic                half_sel_q, half_sel_d;
    logic [PIPE_LAT-1:0] vis_pipe_q, vis_pipe_d;
    logic [PIPE_LAT-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_LAT-1:0] vs_pipe_q, vs_pipe_d;
    logic [23:0]         vid_rgb_q, vid_rgb_d;
    logic [23:0]         pal_entry;
    logic                unused_pal_pad;

    always_comb begin
        rowram_rdaddr_d = visible ? pix_col : '0;
        half_sel_d      = mem.rowram_rddata[0];
        vis_pipe_d      = {vis_pipe_q[PIPE_LAT-2:0], visible};
        hs_pipe_d       = {hs_pipe_q[PIPE_LAT-2:0], hsync_act};
        vs_pipe_d       = {vs_pipe_q[PIPE_LAT-2:0], vsync_act};
        pal_entry       = half_sel_q ? mem.palram_rddata[55:32] : mem.palram_rddata[23:0];
        // Blanked pixels are forced to black whatever the RAMs return.
        vid_rgb_d       = vis_pipe_q[PIPE_LAT-2] ? pal_entry : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowram_rdaddr_q <= '0;
            half_sel_q      <= 1'b0;
            vis_pipe_q      <= '0;
            hs_pipe_q       <= '0;
            vs_pipe_q       <= '0;
            vid_rgb_q       <= '0;
        end else begin
            rowram_rdaddr_q <= rowram_rdaddr_d;
            half_sel_q      <= half_sel_d;
            vis_pipe_q      <= vis_pipe_d;
            hs_pipe_q       <= hs_pipe_d;
            vs_pipe_q       <= vs_pipe_d;
            vid_rgb_q       <= vid_rgb_d;
        end
    end

    // Palette address comes straight off the row-RAM output so the palette read
    // overlaps the half-select capture; held at zero while in reset.
    assign mem.rowram_rdaddr = rowram_rdaddr_q;
    assign mem.palram_rdaddr = rst_n ? mem.rowram_rddata[9:1] : '0;

    assign unused_pal_pad = ^{mem.palram_rddata[63:56], mem.palram_rddata[31:24]};

    assign vid_rgb   = vid_rgb_q;
    assign vid_de    = vis_pipe_q[PIPE_LAT-1];
    assign vid_hsync = hs_pipe_q[PIPE_LAT-1] ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
    assign vid_vsync = vs_pipe_q[PIPE_LAT-1] ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;

endmodule
